alu_ctrl_encoder: RTL

ALU_CTRL_ENCODER -- requirements
Module: alu_ctrl_encoder

---
 rtl/alu_ctrl_encoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_ctrl_encoder.sv
// ALU control encoder: maps a 3-bit ALUControl code plus register fields into a
// packed instruction word and buffers it in a DEPTH-entry FIFO. Define
// ALU_ENC_EMIT_CNT_EN to add the 16-bit emit_cnt pop counter port.
module alu_ctrl_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_aluctl,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [4:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [1:0]               out_aluop,
    output logic [2:0]               out_funct3,
    output logic [6:0]               out_funct7,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
`ifdef ALU_ENC_EMIT_CNT_EN
    ,
    output logic [15:0]              emit_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [1:0]    enc_aluop;
    logic [2:0]    enc_funct3;
    logic [31:0]   word_in;
    logic          push;
    logic          pop;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic [31:0]   mem [DEPTH];

    always_comb begin
        enc_aluop  = 2'b00;
        enc_funct3 = 3'b000;
        case (in_aluctl)
            3'b000:  begin enc_aluop = 2'b01; enc_funct3 = 3'b001; end
            3'b001:  begin enc_aluop = 2'b01; enc_funct3 = 3'b010; end
            3'b010:  begin enc_aluop = 2'b01; enc_funct3 = 3'b011; end
            3'b011:  begin enc_aluop = 2'b01; enc_funct3 = 3'b100; end
            3'b100:  begin enc_aluop = 2'b00; enc_funct3 = 3'b101; end
            3'b101:  begin enc_aluop = 2'b00; enc_funct3 = 3'b110; end
            3'b110:  begin enc_aluop = 2'b00; enc_funct3 = 3'b000; end
            default: begin enc_aluop = 2'b00; enc_funct3 = 3'b111; end
        endcase
    end

    assign word_in = {7'b0000000, in_rs2, in_rs1, enc_funct3, in_rd, in_op, enc_aluop};

    assign full     = (level_reg == LW'(DEPTH));
    assign empty    = (level_reg == '0);
    assign in_ready = !full;
    assign out_valid = !empty;
    assign level    = level_reg;

    // A push while full is refused even if a pop frees a slot this cycle.
    assign push = in_valid && !full;
    assign pop  = out_valid && out_ready;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            level_reg <= level_next;
        end
    end

    // Storage is never reset; stale entries are hidden by the empty mask below.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst && push && (wr_ptr_reg == AW'(gi)))
                mem[gi] <= word_in;
        end
    end

    assign out_instr  = empty ? 32'h0 : mem[rd_ptr_reg];
    assign out_aluop  = out_instr[1:0];
    assign out_funct3 = out_instr[14:12];
    assign out_funct7 = out_instr[31:25];

`ifdef ALU_ENC_EMIT_CNT_EN
    logic [15:0] emit_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            emit_cnt_reg <= '0;
        else if (pop)
            emit_cnt_reg <= emit_cnt_reg + 16'd1;
    end

    assign emit_cnt = emit_cnt_reg;
`endif

endmodule
